// File: rtl/tt_io_bist_if.sv
// Control/status and data bundle between tt_io_bist and its controller/user-core wiring.
// master drives start/abort/resp_in; slave is the BIST engine.
interface tt_io_bist_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
);
  logic             start;
  logic             abort;
  logic [IN_W-1:0]  pat_out;
  logic [OUT_W-1:0] resp_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [OUT_W-1:0] signature;
  logic [15:0]      vec_count;

  modport master (
    output start, abort, resp_in,
    input  pat_out, busy, done, pass, signature, vec_count
  );

  modport slave (
    input  start, abort, resp_in,
    output pat_out, busy, done, pass, signature, vec_count
  );
endinterface

// File: rtl/tt_io_bist.sv
// On-chip self-test for a Tiny Tapeout tile: Galois LFSR drives patterns into the
// user core, a MISR folds its responses into a signature compared against a golden value.
module tt_io_bist #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter logic [((IN_W > OUT_W) ? IN_W : OUT_W)-1:0] POLY = 8'h1D,
  parameter logic [((IN_W > OUT_W) ? IN_W : OUT_W)-1:0] SEED = 8'h01,
  parameter int NUM_VECTORS   = 256,
  parameter int SETTLE_CYCLES = 0,
  parameter logic [OUT_W-1:0] EXPECTED_SIG = 8'h00
) (
  input logic         clk,
  input logic         rst,
  tt_io_bist_if.slave bus
);

  localparam int W = (IN_W > OUT_W) ? IN_W : OUT_W;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [15:0] LAST_VEC  = 16'(NUM_VECTORS - 1);
  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYCLES);
  // With no settle time every cycle of the run is a capture cycle.
  localparam state_t      RUN_STATE = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
    return {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : {W{1'b0}});
  endfunction

  function automatic logic [W-1:0] misr_step(input logic [W-1:0] v,
                                             input logic [OUT_W-1:0] r);
    return lfsr_step(v) ^ W'(r);
  endfunction

  state_t         state, state_nx;
  logic [W-1:0]   lfsr, lfsr_nx;
  logic [W-1:0]   misr, misr_nx;
  logic [15:0]    vec_cnt, vec_cnt_nx;
  logic [7:0]     settle_cnt, settle_nx;
  logic           pass_q, pass_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= '0;
      misr       <= '0;
      vec_cnt    <= '0;
      settle_cnt <= '0;
      pass_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      lfsr       <= lfsr_nx;
      misr       <= misr_nx;
      vec_cnt    <= vec_cnt_nx;
      settle_cnt <= settle_nx;
      pass_q     <= pass_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    lfsr_nx    = lfsr;
    misr_nx    = misr;
    vec_cnt_nx = vec_cnt;
    settle_nx  = settle_cnt;
    pass_nx    = pass_q;

    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          lfsr_nx    = SEED;
          misr_nx    = '0;
          vec_cnt_nx = '0;
          settle_nx  = SETTLE_LD;
          pass_nx    = 1'b0;
          state_nx   = RUN_STATE;
        end
      end
      SETTLE: begin
        // Counter holds the settle cycles still owed including this one.
        settle_nx = settle_cnt - 8'd1;
        if (settle_cnt <= 8'd1) state_nx = CAPTURE;
      end
      CAPTURE: begin
        misr_nx    = misr_step(misr, bus.resp_in);
        vec_cnt_nx = vec_cnt + 16'd1;
        if (vec_cnt == LAST_VEC) begin
          state_nx = DONE;
          pass_nx  = (misr_nx[OUT_W-1:0] == EXPECTED_SIG);
        end else begin
          lfsr_nx   = lfsr_step(lfsr);
          settle_nx = SETTLE_LD;
          state_nx  = RUN_STATE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Abort overrides everything, including a same-cycle start or capture.
    if (bus.abort) begin
      state_nx   = IDLE;
      pass_nx    = 1'b0;
      lfsr_nx    = lfsr;
      misr_nx    = misr;
      vec_cnt_nx = vec_cnt;
      settle_nx  = settle_cnt;
    end
  end

  assign bus.pat_out   = lfsr[IN_W-1:0];
  assign bus.signature = misr[OUT_W-1:0];
  assign bus.vec_count = vec_cnt;
  assign bus.busy      = (state == SETTLE) || (state == CAPTURE);
  assign bus.done      = (state == DONE);
  assign bus.pass      = pass_q;

endmodule

// File: tb/tb_tt_io_bist.sv
// Bench for tt_io_bist: three parameterisations share clk/rst and are driven in turn.
module tb_tt_io_bist;

  typedef struct {
    logic [7:0] pat;
    logic [7:0] sig;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  tt_io_bist_if ifa ();
  tt_io_bist_if ifb ();
  tt_io_bist_if ifc ();

  assign ifa.resp_in = 8'hFF;
  assign ifb.resp_in = ifb.pat_out;
  assign ifc.resp_in = 8'h5A;

  tt_io_bist #(.NUM_VECTORS(4), .SETTLE_CYCLES(0), .EXPECTED_SIG(8'h6C))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  tt_io_bist #(.NUM_VECTORS(4), .SETTLE_CYCLES(2), .EXPECTED_SIG(8'h00))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  tt_io_bist #(.NUM_VECTORS(10), .SETTLE_CYCLES(0))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  vec_t       tbl_a[4];
  vec_t       exp_q[$];
  logic [7:0] pat_q[$];
  logic [7:0] c_pat[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sig_model(input int n, input logic [7:0] r);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ r;
    return s;
  endfunction

  task automatic pulse_start_c();
    @(negedge clk) ifc.start = 1'b1;
    @(negedge clk) ifc.start = 1'b0;
  endtask

  initial begin
    vec_t       e;
    logic [7:0] p;
    int         busy_cnt;
    int         cycles;

    tbl_a[0] = '{8'h01, 8'hFF};
    tbl_a[1] = '{8'h02, 8'h1C};
    tbl_a[2] = '{8'h04, 8'hC7};
    tbl_a[3] = '{8'h08, 8'h6C};
    c_pat = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};

    ifa.start = 0; ifa.abort = 0;
    ifb.start = 0; ifb.abort = 0;
    ifc.start = 0; ifc.abort = 0;
    rst = 1'b1;

    // Reset state
    #12;
    chk("rst_pat",  ifa.pat_out, 0);
    chk("rst_sig",  ifa.signature, 0);
    chk("rst_vec",  ifa.vec_count, 0);
    chk("rst_busy", ifb.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_pass", ifc.pass, 0);
    @(negedge clk) rst = 1'b0;

    // Run A: table-driven vectors through a scoreboard queue
    @(negedge clk) ifa.start = 1'b1;
    foreach (tbl_a[i]) exp_q.push_back(tbl_a[i]);
    @(negedge clk) ifa.start = 1'b0;
    chk("a_busy", ifa.busy, 1);
    for (int i = 0; i < 4; i++) begin
      chk("a_pat", ifa.pat_out, exp_q[0].pat);
      chk("a_done_early", ifa.done, 0);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("a_sig", ifa.signature, e.sig);
    end
    chk("a_done", ifa.done, 1);
    chk("a_pass", ifa.pass, 1);
    chk("a_vec",  ifa.vec_count, 4);
    chk("a_pat_hold", ifa.pat_out, 8'h08);
    chk("a_busy_end", ifa.busy, 0);

    // Run A again from DONE, with a stray start while busy
    @(negedge clk) ifa.start = 1'b1;
    @(negedge clk) ifa.start = 1'b0;
    chk("a2_pat", ifa.pat_out, 8'h01);
    chk("a2_sig", ifa.signature, 0);
    chk("a2_vec", ifa.vec_count, 0);
    chk("a2_pass_clr", ifa.pass, 0);
    @(negedge clk) ifa.start = 1'b1;
    @(negedge clk) ifa.start = 1'b0;
    chk("a2_start_ignored", ifa.vec_count, 2);
    @(negedge clk);
    chk("a2_done_early", ifa.done, 0);
    @(negedge clk);
    chk("a2_done", ifa.done, 1);
    chk("a2_sig_final", ifa.signature, 8'h6C);
    chk("a2_vec", ifa.vec_count, 4);
    chk("a2_pass", ifa.pass, 1);

    // Run B: loopback with settle cycles
    @(negedge clk) ifb.start = 1'b1;
    for (int v = 0; v < 4; v++) begin
      p = 8'(1 << v);
      for (int k = 0; k < 3; k++) pat_q.push_back(p);
    end
    @(negedge clk) ifb.start = 1'b0;
    busy_cnt = 0;
    cycles   = 0;
    while (!ifb.done && cycles < 50) begin
      if (ifb.busy) begin
        busy_cnt++;
        if (pat_q.size() > 0) chk("b_pat_hold", ifb.pat_out, pat_q.pop_front());
        else chk("b_extra_busy", ifb.busy, 0);
      end
      @(negedge clk);
      cycles++;
    end
    chk("b_done_timeout", ifb.done, 1);
    chk("b_busy_cycles", busy_cnt, 12);
    chk("b_sig", ifb.signature, 8'h00);
    chk("b_pass", ifb.pass, 1);
    chk("b_queue_left", pat_q.size(), 0);

    // Run C: LFSR feedback path
    pulse_start_c();
    for (int i = 0; i < 10; i++) begin
      chk("c_pat", ifc.pat_out, c_pat[i]);
      @(negedge clk);
    end
    chk("c_done", ifc.done, 1);
    chk("c_vec", ifc.vec_count, 10);
    chk("c_sig", ifc.signature, sig_model(10, 8'h5A));
    chk("c_pass", ifc.pass, sig_model(10, 8'h5A) == 8'h00);

    // Abort at vec_count=2, together with start
    pulse_start_c();
    @(negedge clk);
    @(negedge clk);
    chk("ab_vec_before", ifc.vec_count, 2);
    ifc.abort = 1'b1;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    ifc.start = 1'b0;
    chk("ab_busy", ifc.busy, 0);
    chk("ab_done", ifc.done, 0);
    chk("ab_pass", ifc.pass, 0);
    chk("ab_vec_hold", ifc.vec_count, 2);
    chk("ab_sig_hold", ifc.signature, sig_model(2, 8'h5A));
    @(negedge clk);
    chk("ab_idle", ifc.busy, 0);
    pulse_start_c();
    chk("ab_reseed", ifc.pat_out, 8'h01);
    chk("ab_sig_clr", ifc.signature, 0);
    chk("ab_vec_clr", ifc.vec_count, 0);
    chk("ab_busy_run", ifc.busy, 1);

    // Asynchronous reset between clock edges mid-run
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_pat",  ifc.pat_out, 0);
    chk("ar_sig",  ifc.signature, 0);
    chk("ar_vec",  ifc.vec_count, 0);
    chk("ar_busy", ifc.busy, 0);
    chk("ar_a_done", ifa.done, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("ar_idle", ifc.busy, 0);
    pulse_start_c();
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("ar_done", ifc.done, 1);
    chk("ar_vec", ifc.vec_count, 10);
    chk("ar_sig", ifc.signature, sig_model(10, 8'h5A));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_io_bist.md
Name: tt_io_bist

Overview:
- Parametrised on-chip self-test engine for a Tiny Tapeout user design.
- Drives pseudo-random vectors onto the design's dedicated inputs and compresses its outputs into a signature with a multiple-input signature register (MISR).
- Runs the same stimulus/response loop a cocotb bench runs, but in silicon, so a bring-up board can check a tile with one start pulse and one pass bit.
- Sits between the pad wrapper and the user core; a mux outside this block selects BIST or functional inputs.

Parameters:
- IN_W, 8, width of generated pattern (matches ui_in).
- OUT_W, 8, width of captured response (matches uo_out).
- POLY, 8'h1D, Galois LFSR/MISR feedback polynomial, width max(IN_W,OUT_W); default x^8+x^4+x^3+x^2+1.
- SEED, 8'h01, LFSR load value at start; must be nonzero.
- NUM_VECTORS, 256, vectors per run, 1..2^16.
- SETTLE_CYCLES, 0, extra cycles between applying a vector and capturing its response, 0..255.
- EXPECTED_SIG, 8'h00, golden signature for the pass compare.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle request to begin a run
- abort  in  1  synchronous abort, returns to IDLE
- pat_out  out  IN_W  vector driven to the user core inputs
- resp_in  in  OUT_W  user core outputs, sampled at capture
- busy  out  1  high in SETTLE or CAPTURE
- done  out  1  high in DONE
- pass  out  1  done && signature==EXPECTED_SIG
- signature  out  OUT_W  current MISR value
- vec_count  out  16  vectors captured so far

Behaviour:
- One clock. Reset is asynchronous and active-high: clock port clk, reset port rst.
- Reset values:
  - state=IDLE
  - pat_out=0, signature=0, vec_count=0
  - busy=0, done=0, pass=0
- LFSR next = {lfsr[W-2:0],0} ^ (lfsr[W-1] ? POLY : 0). pat_out = lfsr[IN_W-1:0].
- MISR next = {sig[W-2:0],0} ^ (sig[W-1] ? POLY : 0) ^ resp_in.
- FSM states IDLE, SETTLE, CAPTURE, DONE:
  - IDLE: on start, load lfsr=SEED, signature=0, vec_count=0, settle counter=SETTLE_CYCLES. Go to SETTLE, or to CAPTURE if SETTLE_CYCLES=0.
  - SETTLE: decrement the settle counter each cycle. At 0, go to CAPTURE. pat_out holds.
  - CAPTURE (one cycle):
    - MISR absorbs resp_in; vec_count++.
    - If vec_count was NUM_VECTORS-1, go to DONE with the LFSR frozen.
    - Otherwise advance the LFSR, reload the settle counter, and go to SETTLE (or stay in CAPTURE if SETTLE_CYCLES=0).
  - DONE: signature, vec_count and pat_out hold. A start here restarts the run exactly as from IDLE.
- Latency: a run is NUM_VECTORS*(SETTLE_CYCLES+1) cycles from the start edge. done rises the cycle after the last capture.
- start while busy: ignored, no restart.
- abort in any state: IDLE next cycle, busy=done=pass=0; signature and vec_count keep their last values.
- abort and start in the same cycle: abort wins.
- Async reset mid-run: everything returns to reset values immediately; a new start is needed.
- The LFSR wraps after 2^W-1 vectors for a maximal POLY. NUM_VECTORS beyond that repeats the sequence and is legal.
- pass is registered from the final signature and equals 0 outside DONE.

Test Plan:
- Defaults, SETTLE_CYCLES=0, NUM_VECTORS=4, resp_in tied 8'hFF, start pulse ->
  - pat_out 01,02,04,08 on consecutive cycles
  - signature FF,1C,C7,6C
  - done 5 cycles after the start edge
  - vec_count=4
  - pass=1 iff EXPECTED_SIG=8'h6C
- Loopback resp_in=pat_out, NUM_VECTORS=4, SETTLE_CYCLES=2 -> each vector held 3 cycles, final signature 8'h00, busy high 12 cycles.
- NUM_VECTORS=10, pat_out sequence -> after 80, next vector is 1D then 3A (feedback path).
- abort asserted mid-run at vec_count=2 -> IDLE next cycle, busy=0, done=0; a following start reloads SEED and clears signature.
- start pulsed again while busy -> no effect; start in DONE -> clean rerun with an identical signature.
- rst asserted between clock edges mid-run -> outputs zero without waiting for clk; start after rst release gives a normal run.
